ccc_apb_cfg_master: RTL and testbench

APB initiator that drives the fabric CCC dynamic-configuration port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA), the other end of that interface.
- Accepts single read/write commands from fabric control logic.
- Performs one APB transfer per command.
- Can wait for the PLL to re-acquire LOCK after a write, with a stability filter and a timeout.
- Sits between the system controller logic and the CCC instance in the UART/GPIO fabric subsystem.

---
 rtl/ccc_cfg_pkg.sv | 31 +++
 rtl/ccc_lock_sync.sv | 54 +++++
 rtl/ccc_apb_cfg_master.sv | 115 +++++++++++
 tb/tb_ccc_apb_cfg_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccc_cfg_pkg.sv
// Shared types and constants for the CCC dynamic-configuration APB master.
// Callers use the named register addresses when building commands.
package ccc_cfg_pkg;

    localparam int APB_AW = 6;
    localparam int APB_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_LOCK_WAIT,
        ST_RESP
    } cfg_state_t;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic              wait_lock;
    } cfg_cmd_t;

    localparam logic [APB_AW-1:0] CCC_REG_PLL_CTRL  = 6'h00;
    localparam logic [APB_AW-1:0] CCC_REG_PLL_REF   = 6'h01;
    localparam logic [APB_AW-1:0] CCC_REG_PLL_FB    = 6'h02;
    localparam logic [APB_AW-1:0] CCC_REG_PLL_POST  = 6'h03;
    localparam logic [APB_AW-1:0] CCC_REG_OUT0_DIV  = 6'h05;
    localparam logic [APB_AW-1:0] CCC_REG_OUT1_DIV  = 6'h06;
    localparam logic [APB_AW-1:0] CCC_REG_STATUS    = 6'h2A;

endpackage

// File: rtl/ccc_lock_sync.sv
// PLL LOCK synchronizer with falling-edge detect and a stability filter
// that reports when LOCK has been continuously high for LOCK_STABLE cycles.
module ccc_lock_sync #(
    parameter int LOCK_STABLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock,
    input  logic en,
    input  logic clr,
    output logic lock_sync,
    output logic lock_fall,
    output logic lock_stable_done
);

    localparam logic [7:0] STABLE_MAX = 8'(LOCK_STABLE);
    localparam logic [7:0] STABLE_M1  = 8'(LOCK_STABLE - 1);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= lock;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (!s2)
                cnt <= '0;
            else if (cnt != STABLE_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    // Done when this cycle's count brings the run of high samples to LOCK_STABLE.
    assign lock_stable_done = en & s2 & (cnt >= STABLE_M1);
    assign lock_sync        = s2;
    assign lock_fall        = s3 & ~s2;

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the CCC dynamic-configuration port: one fixed two-cycle
// transfer per command, optionally followed by a filtered wait for PLL LOCK.
module ccc_apb_cfg_master
    import ccc_cfg_pkg::*;
#(
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int TO_W         = 13
) (
    input  logic              PCLK,
    input  logic              PRESET_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    input  logic              cmd_wait_lock,
    output logic              rsp_valid,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              LOCK,
    output logic              lock_sync,
    output logic              lock_lost
);

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(LOCK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    cfg_state_t  state;
    cfg_state_t  state_nxt;
    cfg_cmd_t    cmd_q;
    logic [TO_W-1:0] to_cnt;
    logic        timeout;
    logic        handshake;
    logic        apb_sel;
    logic        lock_fall;
    logic        stable_done;
    logic        rsp_enter;

    ccc_lock_sync #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_sync (
        .clk              (PCLK),
        .rst_n            (PRESET_N),
        .lock             (LOCK),
        .en               (state == ST_LOCK_WAIT),
        .clr              (state == ST_ACCESS),
        .lock_sync        (lock_sync),
        .lock_fall        (lock_fall),
        .lock_stable_done (stable_done)
    );

    // Gated by reset so every output reads 0 while PRESET_N is low.
    assign cmd_ready = (state == ST_IDLE) & PRESET_N;
    assign handshake = cmd_valid & cmd_ready;
    assign timeout   = (to_cnt >= TO_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (handshake) state_nxt = ST_SETUP;
            ST_SETUP:     state_nxt = ST_ACCESS;
            ST_ACCESS:    state_nxt = (cmd_q.write & cmd_q.wait_lock)
                                      ? ST_LOCK_WAIT : ST_RESP;
            ST_LOCK_WAIT: if (stable_done || timeout) state_nxt = ST_RESP;
            ST_RESP:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign rsp_enter = (state_nxt == ST_RESP) & (state != ST_RESP);

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            to_cnt    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake)
                cmd_q <= '{cmd_write, cmd_addr, cmd_wdata, cmd_wait_lock};
            if (state == ST_ACCESS)
                to_cnt <= '0;
            else if (state == ST_LOCK_WAIT && to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;
            // Success has priority when both conditions land together.
            if (rsp_enter) begin
                rsp_rdata <= (state == ST_ACCESS && !cmd_q.write) ? PRDATA : '0;
                rsp_err   <= (state == ST_LOCK_WAIT) & ~stable_done;
            end
            if (handshake)
                lock_lost <= 1'b0;
            else if (lock_fall && state == ST_IDLE)
                lock_lost <= 1'b1;
        end
    end

    assign apb_sel   = (state == ST_SETUP) | (state == ST_ACCESS);
    assign PSEL      = apb_sel;
    assign PENABLE   = (state == ST_ACCESS);
    assign PWRITE    = apb_sel & cmd_q.write;
    assign PADDR     = apb_sel ? cmd_q.addr  : '0;
    assign PWDATA    = apb_sel ? cmd_q.wdata : '0;
    assign rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Directed bench for ccc_apb_cfg_master: APB timing, lock wait success and
// timeout, lock_lost, back-to-back requests and mid-transfer reset.
module tb_ccc_apb_cfg_master;

    localparam int LS = 16;
    localparam int LT = 4096;
    localparam int TW = 13;

    logic       PCLK = 1'b0;
    logic       PRESET_N;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_wait_lock;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       LOCK;
    logic       lock_sync;
    logic       lock_lost;

    int n_assert = 0;
    int n_fail   = 0;

    ccc_apb_cfg_master #(
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .TO_W         (TW)
    ) dut (
        .PCLK          (PCLK),
        .PRESET_N      (PRESET_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wait_lock (cmd_wait_lock),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .LOCK          (LOCK),
        .lock_sync     (lock_sync),
        .lock_lost     (lock_lost)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int hs;
        int su;
        int rv;

        PRESET_N      = 1'b0;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_addr      = '0;
        cmd_wdata     = '0;
        cmd_wait_lock = 1'b0;
        PRDATA        = '0;
        LOCK          = 1'b0;

        // Reset values
        #2;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_lock_sync", lock_sync, 0);
        chk("rst_lock_lost", lock_lost, 0);
        tick; tick;
        PRESET_N = 1'b1;
        LOCK     = 1'b1;
        tick;
        chk("ready_after_rst", cmd_ready, 1);
        repeat (4) tick;
        chk("lock_sync_hi", lock_sync, 1);

        // Read 0x2A, PRDATA 0x5C
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h2A;
        PRDATA = 8'h5C;
        tick;
        cmd_valid = 1'b0;
        chk("rd_setup_psel", PSEL, 1);
        chk("rd_setup_pen", PENABLE, 0);
        chk("rd_setup_pwrite", PWRITE, 0);
        chk("rd_setup_paddr", PADDR, 6'h2A);
        chk("rd_setup_ready", cmd_ready, 0);
        tick;
        chk("rd_acc_psel", PSEL, 1);
        chk("rd_acc_pen", PENABLE, 1);
        chk("rd_acc_paddr", PADDR, 6'h2A);
        chk("rd_acc_rspv", rsp_valid, 0);
        tick;
        PRDATA = 8'hFF;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 8'h5C);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_rsp_psel", PSEL, 0);
        chk("rd_rsp_ready", cmd_ready, 0);
        tick;
        chk("rd_idle_rspv", rsp_valid, 0);
        chk("rd_idle_hold", rsp_rdata, 8'h5C);
        chk("rd_idle_ready", cmd_ready, 1);

        // Write 0x05 <- 0xA3, no lock wait
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h05;
        cmd_wdata = 8'hA3; cmd_wait_lock = 1'b0;
        tick;
        cmd_valid = 1'b0;
        chk("wr_setup_pwrite", PWRITE, 1);
        chk("wr_setup_pwdata", PWDATA, 8'hA3);
        chk("wr_setup_paddr", PADDR, 6'h05);
        chk("wr_setup_pen", PENABLE, 0);
        tick;
        chk("wr_acc_pwrite", PWRITE, 1);
        chk("wr_acc_pwdata", PWDATA, 8'hA3);
        chk("wr_acc_pen", PENABLE, 1);
        tick;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_pwdata", PWDATA, 0);
        chk("wr_rsp_pwrite", PWRITE, 0);
        tick;

        // Write with lock wait: LOCK low 100 cycles, then high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h02;
        cmd_wdata = 8'h11; cmd_wait_lock = 1'b1;
        tick;
        cmd_valid = 1'b0;
        LOCK = 1'b0;
        tick;
        tick;
        chk("lw_psel", PSEL, 0);
        chk("lw_paddr", PADDR, 0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (rsp_valid) seen++;
        end
        chk("lw_no_early_rsp", seen, 0);
        LOCK = 1'b1;
        seen = 0;
        for (int i = 0; i < LS + 1; i++) begin
            tick;
            if (rsp_valid) seen++;
        end
        chk("lw_no_rsp_before_stable", seen, 0);
        tick;
        chk("lw_rsp_valid", rsp_valid, 1);
        chk("lw_rsp_err", rsp_err, 0);
        chk("lw_rsp_rdata", rsp_rdata, 0);
        chk("lw_no_lock_lost", lock_lost, 0);
        tick;

        // Lock wait timeout after a short LOCK glitch
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h03;
        cmd_wdata = 8'h22; cmd_wait_lock = 1'b1;
        tick;
        cmd_valid = 1'b0;
        LOCK = 1'b0;
        tick;
        tick;
        seen = 0;
        for (int i = 1; i < LT; i++) begin
            tick;
            if (i == 20) LOCK = 1'b1;
            if (i == 30) LOCK = 1'b0;
            if (rsp_valid) seen++;
        end
        chk("to_no_early_rsp", seen, 0);
        tick;
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        tick;
        chk("to_err_hold", rsp_err, 1);

        // lock_lost on an idle LOCK drop
        LOCK = 1'b1;
        repeat (5) tick;
        chk("ll_pre", lock_lost, 0);
        LOCK = 1'b0;
        tick; tick;
        chk("ll_not_yet", lock_lost, 0);
        tick;
        chk("ll_set", lock_lost, 1);

        // cmd_valid held high: one transfer per handshake
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h11;
        PRDATA = 8'h77;
        hs = 0; su = 0; rv = 0;
        for (int c = 0; c < 8; c++) begin
            if (cmd_valid && cmd_ready) hs++;
            if (PSEL && !PENABLE) su++;
            if (rsp_valid) rv++;
            if (c == 1) chk("ll_cleared", lock_lost, 0);
            if (c == 7) cmd_valid = 1'b0;
            tick;
        end
        chk("bb_handshakes", hs, 2);
        chk("bb_setups", su, 2);
        chk("bb_responses", rv, 2);
        chk("bb_idle_psel", PSEL, 0);
        chk("bb_rdata", rsp_rdata, 8'h77);

        // Reset asserted during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h06;
        cmd_wdata = 8'h3C; cmd_wait_lock = 1'b0;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("ra_access_pen", PENABLE, 1);
        #1;
        PRESET_N = 1'b0;
        #1;
        chk("ra_psel", PSEL, 0);
        chk("ra_penable", PENABLE, 0);
        chk("ra_rsp_valid", rsp_valid, 0);
        chk("ra_pwdata", PWDATA, 0);
        tick; tick;
        PRESET_N = 1'b1;
        tick;
        chk("ra_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            tick;
        end
        chk("ra_no_rsp", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
